// File: rtl/int_to_float.sv
// Signed 32-bit integer to IEEE-754 single-precision converter.
// Sequential FSM with stb/ack handshakes; normalisation shifts one bit per cycle.
module int_to_float #(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic [2:0]  state_o
);

  // Handshake: a transfer happens on a rising clk edge where both the
  // strobe (valid) and the ack (ready) of a channel are high; the sender
  // holds its data stable while its strobe is high and unacknowledged.

  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    CONVERT   = 3'd1,
    NORMALISE = 3'd2,
    ROUND     = 3'd3,
    PACK      = 3'd4,
    PUT_Z     = 3'd5
  } state_t;

  state_t      state_q;
  logic        ack_q;
  logic        stb_q;
  logic [31:0] out_q;
  logic [31:0] a_q;
  logic [31:0] m_q;
  logic [7:0]  e_q;
  logic        s_q;
  logic [22:0] frac_q;
  logic [31:0] z_q;

  logic        guard;
  logic        rnd;
  logic        sticky;
  logic        round_up;
  logic [23:0] frac_inc;

  assign guard    = m_q[7];
  assign rnd      = m_q[6];
  assign sticky   = |m_q[5:0];
  assign round_up = ROUND_NEAREST && guard && (rnd || sticky || m_q[8]);
  // Hidden bit is always 1 here, so a carry out of the fraction is a carry
  // out of the full 24-bit mantissa; the fraction bits are then already 0.
  assign frac_inc = {1'b0, m_q[30:8]} + 24'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GET_A;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      out_q   <= 32'd0;
      a_q     <= 32'd0;
      m_q     <= 32'd0;
      e_q     <= 8'd0;
      s_q     <= 1'b0;
      frac_q  <= 23'd0;
      z_q     <= 32'd0;
    end else begin
      case (state_q)
        GET_A: begin
          if (!ack_q) begin
            ack_q <= 1'b1;
          end else if (input_a_stb) begin
            a_q     <= input_a;
            ack_q   <= 1'b0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          s_q <= a_q[31];
          m_q <= a_q[31] ? (~a_q + 32'd1) : a_q;
          e_q <= 8'd31;
          if (a_q == 32'd0) begin
            z_q     <= 32'd0;
            state_q <= PUT_Z;
          end else begin
            state_q <= NORMALISE;
          end
        end
        NORMALISE: begin
          if (!m_q[31]) begin
            m_q <= m_q << 1;
            e_q <= e_q - 8'd1;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (round_up) begin
            frac_q <= frac_inc[22:0];
            e_q    <= e_q + {7'd0, frac_inc[23]};
          end else begin
            frac_q <= m_q[30:8];
          end
          state_q <= PACK;
        end
        PACK: begin
          z_q     <= {s_q, e_q + 8'd127, frac_q};
          state_q <= PUT_Z;
        end
        PUT_Z: begin
          if (!stb_q) begin
            out_q <= z_q;
            stb_q <= 1'b1;
          end else if (output_z_ack) begin
            stb_q   <= 1'b0;
            state_q <= GET_A;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z_stb = stb_q;
  assign output_z     = out_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_int_to_float.sv
// Bench for int_to_float: directed vectors, expected results queued by the
// drivers and popped by independent output monitors.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_r, z_r, a_t, z_t;
  logic        stb_r, iack_r, zstb_r, zack_r;
  logic        stb_t, iack_t, zstb_t, zack_t;
  logic [2:0]  st_r, st_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_cyc = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  logic [31:0] exp_t_q[$];
  int          lat_t_q[$];
  int          acc_t_q[$];

  int_to_float #(.ROUND_NEAREST(1'b1)) dut_r (
    .clk(clk), .rst(rst),
    .input_a(a_r), .input_a_stb(stb_r), .input_a_ack(iack_r),
    .output_z(z_r), .output_z_stb(zstb_r), .output_z_ack(zack_r),
    .state_o(st_r)
  );

  int_to_float #(.ROUND_NEAREST(1'b0)) dut_t (
    .clk(clk), .rst(rst),
    .input_a(a_t), .input_a_stb(stb_t), .input_a_ack(iack_t),
    .output_z(z_t), .output_z_stb(zstb_t), .output_z_ack(zack_t),
    .state_o(st_t)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a);
    logic [31:0] mag;
    int msb;
    if (a == 32'd0) return 2;
    mag = a[31] ? (~a + 32'd1) : a;
    msb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
    return 5 + (31 - msb);
  endfunction

  task automatic drive_r(input logic [31:0] a, input logic [31:0] z, input bit push);
    int n = 0;
    a_r = a;
    stb_r = 1'b1;
    while (1) begin
      @(negedge clk);
      if (iack_r === 1'b1) break;
      n++;
      if (n > 200) begin
        check("accept_timeout_rne", 32'd0, 32'd1);
        stb_r = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    stb_r = 1'b0;
    a_r = 32'hDEADBEEF;
    if (push) begin
      exp_q.push_back(z);
      lat_q.push_back(exp_lat(a));
      acc_q.push_back(cyc);
    end
  endtask

  task automatic drive_t(input logic [31:0] a, input logic [31:0] z);
    int n = 0;
    a_t = a;
    stb_t = 1'b1;
    while (1) begin
      @(negedge clk);
      if (iack_t === 1'b1) break;
      n++;
      if (n > 200) begin
        check("accept_timeout_trunc", 32'd0, 32'd1);
        stb_t = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    stb_t = 1'b0;
    a_t = 32'hDEADBEEF;
    exp_t_q.push_back(z);
    lat_t_q.push_back(exp_lat(a));
    acc_t_q.push_back(cyc);
  endtask

  // scoreboard monitor, round-to-nearest instance
  initial begin
    logic [31:0] held;
    int h_n;
    zack_r = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && zstb_r === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output_rne", z_r, 32'd0);
        end else begin
          check("z_rne", z_r, exp_q.pop_front());
          check("latency_rne", cyc - acc_q.pop_front(), lat_q.pop_front());
        end
        held = z_r;
        h_n = hold_cyc;
        hold_cyc = 0;
        for (int h = 0; h < h_n; h++) begin
          @(negedge clk);
          check("hold_stb", {31'd0, zstb_r}, 32'd1);
          check("hold_z", z_r, held);
          check("hold_in_ack", {31'd0, iack_r}, 32'd0);
        end
        zack_r = 1'b1;
        @(negedge clk);
        zack_r = 1'b0;
        check("stb_drop_rne", {31'd0, zstb_r}, 32'd0);
      end
    end
  end

  // scoreboard monitor, truncating instance
  initial begin
    zack_t = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && zstb_t === 1'b1) begin
        if (exp_t_q.size() == 0) begin
          check("unexpected_output_trunc", z_t, 32'd0);
        end else begin
          check("z_trunc", z_t, exp_t_q.pop_front());
          check("latency_trunc", cyc - acc_t_q.pop_front(), lat_t_q.pop_front());
        end
        zack_t = 1'b1;
        @(negedge clk);
        zack_t = 1'b0;
        check("stb_drop_trunc", {31'd0, zstb_t}, 32'd0);
      end
    end
  end

  logic [31:0] va[14] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000,
                          32'h01000001, 32'h01000003, 32'h01000007, 32'h7FFFFFFF,
                          32'h02000003, 32'h00FFFFFF, 32'h00000064, 32'hFFFFFF9C,
                          32'hFFFFFFF9, 32'h40000000};
  logic [31:0] vz[14] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'hCF000000,
                          32'h4B800000, 32'h4B800002, 32'h4B800004, 32'h4F000000,
                          32'h4C000001, 32'h4B7FFFFF, 32'h42C80000, 32'hC2C80000,
                          32'hC0E00000, 32'h4E800000};
  logic [31:0] ta[4] = '{32'h7FFFFFFF, 32'h01000003, 32'h02000003, 32'hFFFFFFFF};
  logic [31:0] tz[4] = '{32'h4EFFFFFF, 32'h4B800001, 32'h4C000000, 32'hBF800000};

  initial begin
    rst = 1'b0;
    a_r = 32'd0; stb_r = 1'b0;
    a_t = 32'd0; stb_t = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ack", {31'd0, iack_r}, 32'd0);
    check("reset_stb", {31'd0, zstb_r}, 32'd0);
    check("reset_z", z_r, 32'd0);
    check("reset_state", {29'd0, st_r}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ack_after_reset", {31'd0, iack_r}, 32'd1);

    for (int i = 0; i < 14; i++) drive_r(va[i], vz[i], 1'b1);

    // back-pressure: consumer withholds ack for 20 cycles
    hold_cyc = 20;
    drive_r(32'h12345678, 32'h4D91A2B4, 1'b1);
    drive_r(32'h00000002, 32'h40000000, 1'b1);

    // reset while normalising a=5 discards the conversion
    drive_r(32'h00000005, 32'h40A00000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("mid_state_normalise", {29'd0, st_r}, 32'd2);
    rst = 1'b0;
    #1;
    check("midreset_in_ack", {31'd0, iack_r}, 32'd0);
    check("midreset_stb", {31'd0, zstb_r}, 32'd0);
    check("midreset_z", z_r, 32'd0);
    check("midreset_state", {29'd0, st_r}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive_r(32'h00000007, 32'h40E00000, 1'b1);

    for (int i = 0; i < 4; i++) drive_t(ta[i], tz[i]);

    for (int i = 0; i < 300 && (exp_q.size() + exp_t_q.size()) > 0; i++) @(negedge clk);
    check("drain", exp_q.size() + exp_t_q.size(), 32'd0);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
